// File: rtl/shift_pkg.sv
// Shared constants for the bidirectional shift register: direction encodings
// and the smallest width that leaves a distinct entry and exit bit.
package shift_pkg;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
  localparam int   MIN_WIDTH = 2;
endpackage

// File: rtl/bidirectional_shift_register_if.sv
// Serial-in / parallel-out bundle: serial bit, enable and direction in, register contents out.
interface bidirectional_shift_register_if #(
  parameter int N = 4
);
  logic         d;
  logic         en;
  logic         dir;
  logic [N-1:0] Q;

  modport master (output d, output en, output dir, input  Q);
  modport slave  (input  d, input  en, input  dir, output Q);
endinterface

// File: rtl/bidirectional_shift_register.sv
// N-bit serial-in, parallel-out shift register with per-cycle selectable direction.
// Priority on each rising edge: reset, then enable, then direction.
module bidirectional_shift_register
  import shift_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  bidirectional_shift_register_if.slave bus
);

  generate
    if (N < MIN_WIDTH) begin : g_width_check
      $error("bidirectional_shift_register: N must be at least 2");
    end
  endgenerate

  logic [N-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (bus.en) begin
      // Left moves data toward the MSB and enters at bit 0; right is the mirror.
      if (bus.dir == DIR_LEFT) begin
        r_q <= {r_q[N-2:0], bus.d};
      end else if (bus.dir == DIR_RIGHT) begin
        r_q <= {bus.d, r_q[N-1:1]};
      end
    end
  end

  assign bus.Q = r_q;

endmodule

// File: tb/tb_bidirectional_shift_register.sv
// Scoreboard bench: stimulus pushes hand-computed Q values, a monitor pops and compares.
module tb_bidirectional_shift_register;
  localparam int N = 4;

  logic clk;
  logic rst;

  bidirectional_shift_register_if #(.N(N)) bus ();

  bidirectional_shift_register #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  // One edge of stimulus; the expected Q after that edge goes to the scoreboard.
  task automatic step(input logic r, input logic e, input logic dr, input logic dd,
                      input logic [N-1:0] exp, input string nm);
    @(negedge clk);
    rst     = r;
    bus.en  = e;
    bus.dir = dr;
    bus.d   = dd;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [N-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (bus.Q !== e) begin
        errors++;
        $display("FAIL %s: Q got %b expected %b", n, bus.Q, e);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.dir = 1'b0;
    bus.d   = 1'b0;

    // Reset wins over an enabled left shift of a 1
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, "reset");
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, "post_reset_hold0");
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, "post_reset_hold1");
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "post_reset_hold2");

    // Left fill, then MSB dropped
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, "left_fill1");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0011, "left_fill2");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0111, "left_fill3");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, "left_fill4");
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b1110, "left_msb_drop");

    // Right fill, then LSB dropped
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "reset_before_right");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, "right_fill1");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1100, "right_fill2");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1110, "right_fill3");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, "right_fill4");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0111, "right_lsb_drop");

    // Alternating enable; holds vary dir so a hold that shifts is visible
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "reset_before_alt");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, "alt_left1");
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, "alt_hold1");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0011, "alt_left2");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, "alt_hold2");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1001, "alt_right1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, "alt_hold3");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1100, "alt_right2");
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b1100, "alt_hold4");

    // Direction reversal from 0110
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "reset_before_rev");
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, "rev_load1");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, "rev_load2");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0011, "rev_load3");
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, "rev_load4");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, "rev_right");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0111, "rev_left");

    // Reset mid-operation from 1011
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "reset_before_mid");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, "mid_load1");
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, "mid_load2");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, "mid_load3");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, "mid_load4");
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, "mid_reset");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, "mid_after_reset");

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending %0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
